rv32im_lsu: RTL and testbench
=============================

Name: rv32im_lsu

Overview:
Load/store unit for the RV32IM core. It sits between the execute unit (EXU) and a 32-bit word-organised data memory with byte write enables. It converts an LSU opcode and byte address into a word-aligned memory request, byte-lane write data and a write mask. It extracts and extends load data returned by memory. A registered sticky flag records misaligned-access errors.

Parameters:
- API_DATA_WIDTH, 32, data/address width; only 32 is supported.
- LSU_OPCODE_WIDTH, 4, width of the opcode field.

Ports:
- clk_i, input, 1, core clock.
- rst_ni, input, 1, asynchronous active-low reset.
- lsu_opcode_i, input, 4, operation. Encoding:
  - NONE=0000, LB=0001, LH=0010, LW=0011, LBU=0100, LHU=0101.
  - SB=1000, SH=1001, SW=1010.
  - Any other code is treated as NONE.
- addr_mem_i, input, 32, byte address from EXU.
- val_memwr_i, input, 32, store data from EXU (rs2).
- val_memrd_i, input, 32, word read from memory at addr_mem_o.
- val_memwr_o, output, 32, lane-replicated store data to memory.
- val_memrd_o, output, 32, extended load result to EXU.
- addr_mem_o, output, 32, word-aligned address {addr_mem_i[31:2],2'b00}.
- wr_mask_o, output, 4, byte write enables; bit n = byte lane n.
- enable_o, output, 1, memory access request valid.
- misalign_o, output, 1, current access is misaligned (combinational).
- misalign_sticky_o, output, 1, registered sticky error flag.
- err_clr_i, input, 1, synchronous clear of misalign_sticky_o.

Behaviour:
- Request path is purely combinational, with zero latency from inputs to outputs.
- off = addr_mem_i[1:0].
- addr_mem_o is always the word-aligned address, for every opcode including NONE.
- Misalignment rules:
  - LH/LHU/SH misaligned when off[0]=1.
  - LW/SW misaligned when off≠0.
  - Byte ops and NONE are never misaligned.
- A misaligned access is suppressed: enable_o=0, wr_mask_o=0000, val_memrd_o=0, misalign_o=1.
- enable_o=1 for any aligned load or store. enable_o=0 for NONE.
- Loads:
  - wr_mask_o=0000 and val_memwr_o=0.
  - sh = val_memrd_i >> (8*off).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: val_memrd_i unchanged.
- Stores:
  - val_memrd_o=0.
  - SB: val_memwr_o={4{val_memwr_i[7:0]}}, wr_mask_o=0001<<off.
  - SH: val_memwr_o={2{val_memwr_i[15:0]}}, wr_mask_o=0011<<off.
  - SW: val_memwr_o=val_memwr_i, wr_mask_o=1111.
  - Upper bits of val_memwr_i beyond the access size are ignored.
- NONE/unknown opcode: enable_o=0, wr_mask_o=0, val_memwr_o=0, val_memrd_o=0, misalign_o=0.
- Sticky flag:
  - On rst_ni low (asynchronous), misalign_sticky_o=0.
  - On each rising clk_i: err_clr_i=1 clears the flag (clear has priority). Otherwise the flag becomes 1 if misalign_o=1, else it holds.
  - Reset asserted mid-operation clears the flag immediately. Combinational outputs are unaffected by reset.
- Reset values: only misalign_sticky_o is stateful (0). All other outputs follow their inputs at all times.

Test Plan:
- Byte loads, val_memrd_i=0x08439341:
  - LBU off0..3 -> 0x41, 0x93, 0x43, 0x08.
  - LB off1 -> 0xFFFFFF93; LB off2 -> 0x00000043.
  - enable_o=1, wr_mask_o=0000.
- Half/word loads, same data:
  - LHU off0 -> 0x00009341; LHU off2 -> 0x00000843.
  - LH off0 -> 0xFFFF9341.
  - LW off0 -> 0x08439341.
  - LH at addr 1 -> misalign_o=1, enable_o=0, val_memrd_o=0.
- Byte stores, val_memwr_i=0x08439341, addr 4..7:
  - addr_mem_o=4, val_memwr_o=0x41414141.
  - wr_mask_o=0001, 0010, 0100, 1000 respectively.
- Half/word stores:
  - SH addr4 -> mask 0011, data 0x93419341, addr_mem_o=4.
  - SH addr6 -> mask 1100, same data.
  - SW addr4 -> mask 1111, data 0x08439341.
- Misaligned SW addr 7 -> enable_o=0, wr_mask_o=0000, misalign_o=1. After the next clk_i edge misalign_sticky_o=1, and it holds through subsequent NONE cycles.
- Sticky clear and reset:
  - err_clr_i=1 for one edge -> misalign_sticky_o=0.
  - Re-set the flag, then pull rst_ni low between edges -> flag drops to 0 immediately without a clock.
  - NONE opcode -> enable_o=0, wr_mask_o=0, addr_mem_o=aligned address.

Source files
------------

// File: rtl/rv32im_lsu.sv
// Load/store unit for the RV32IM core: combinational request/extract path between
// EXU and a word-organised data memory, plus a registered sticky misalignment flag.
module rv32im_lsu #(
  parameter int unsigned API_DATA_WIDTH   = 32,
  parameter int unsigned LSU_OPCODE_WIDTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
  input  logic [API_DATA_WIDTH-1:0]   addr_mem_i,
  input  logic [API_DATA_WIDTH-1:0]   val_memwr_i,
  input  logic [API_DATA_WIDTH-1:0]   val_memrd_i,
  output logic [API_DATA_WIDTH-1:0]   val_memwr_o,
  output logic [API_DATA_WIDTH-1:0]   val_memrd_o,
  output logic [API_DATA_WIDTH-1:0]   addr_mem_o,
  output logic [3:0]                  wr_mask_o,
  output logic                        enable_o,
  output logic                        misalign_o,
  output logic                        misalign_sticky_o,
  input  logic                        err_clr_i
);

  typedef enum logic [LSU_OPCODE_WIDTH-1:0] {
    OP_NONE = 4'b0000,
    OP_LB   = 4'b0001,
    OP_LH   = 4'b0010,
    OP_LW   = 4'b0011,
    OP_LBU  = 4'b0100,
    OP_LHU  = 4'b0101,
    OP_SB   = 4'b1000,
    OP_SH   = 4'b1001,
    OP_SW   = 4'b1010
  } lsu_op_e;

  logic [1:0]  off;
  logic [15:0] sh;

  assign off        = addr_mem_i[1:0];
  assign addr_mem_o = {addr_mem_i[API_DATA_WIDTH-1:2], 2'b00};
  // Only the low halfword of the lane-shifted read word is ever extracted.
  assign sh         = 16'(val_memrd_i >> {off, 3'b000});

  always_comb begin
    val_memwr_o = '0;
    val_memrd_o = '0;
    wr_mask_o   = '0;
    enable_o    = 1'b0;
    misalign_o  = 1'b0;
    case (lsu_opcode_i)
      OP_LB: begin
        enable_o    = 1'b1;
        val_memrd_o = {{(API_DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      end
      OP_LBU: begin
        enable_o    = 1'b1;
        val_memrd_o = {{(API_DATA_WIDTH-8){1'b0}}, sh[7:0]};
      end
      OP_LH: begin
        if (off[0]) begin
          misalign_o = 1'b1;
        end else begin
          enable_o    = 1'b1;
          val_memrd_o = {{(API_DATA_WIDTH-16){sh[15]}}, sh};
        end
      end
      OP_LHU: begin
        if (off[0]) begin
          misalign_o = 1'b1;
        end else begin
          enable_o    = 1'b1;
          val_memrd_o = {{(API_DATA_WIDTH-16){1'b0}}, sh};
        end
      end
      OP_LW: begin
        if (off != 2'b00) begin
          misalign_o = 1'b1;
        end else begin
          enable_o    = 1'b1;
          val_memrd_o = val_memrd_i;
        end
      end
      OP_SB: begin
        enable_o    = 1'b1;
        val_memwr_o = {4{val_memwr_i[7:0]}};
        wr_mask_o   = 4'b0001 << off;
      end
      OP_SH: begin
        if (off[0]) begin
          misalign_o = 1'b1;
        end else begin
          enable_o    = 1'b1;
          val_memwr_o = {2{val_memwr_i[15:0]}};
          wr_mask_o   = 4'b0011 << off;
        end
      end
      OP_SW: begin
        if (off != 2'b00) begin
          misalign_o = 1'b1;
        end else begin
          enable_o    = 1'b1;
          val_memwr_o = val_memwr_i;
          wr_mask_o   = 4'b1111;
        end
      end
      default: ;
    endcase
  end

  // Clear wins over a simultaneous new misalignment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misalign_sticky_o <= 1'b0;
    end else if (err_clr_i) begin
      misalign_sticky_o <= 1'b0;
    end else if (misalign_o) begin
      misalign_sticky_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32im_lsu.sv
// Scoreboard bench for rv32im_lsu: driver pushes reference-model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_rv32im_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  lsu_opcode_i = '0;
  logic [31:0] addr_mem_i = '0;
  logic [31:0] val_memwr_i = '0;
  logic [31:0] val_memrd_i = '0;
  logic [31:0] val_memwr_o, val_memrd_o, addr_mem_o;
  logic [3:0]  wr_mask_o;
  logic        enable_o, misalign_o, misalign_sticky_o;
  logic        err_clr_i = 1'b0;

  rv32im_lsu #(.API_DATA_WIDTH(32), .LSU_OPCODE_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lsu_opcode_i(lsu_opcode_i),
    .addr_mem_i(addr_mem_i), .val_memwr_i(val_memwr_i), .val_memrd_i(val_memrd_i),
    .val_memwr_o(val_memwr_o), .val_memrd_o(val_memrd_o), .addr_mem_o(addr_mem_o),
    .wr_mask_o(wr_mask_o), .enable_o(enable_o), .misalign_o(misalign_o),
    .misalign_sticky_o(misalign_sticky_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  mask;
    logic        en, mis, sticky, chk_w;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic model_sticky = 1'b0;
  logic prev_mis = 1'b0;
  logic prev_clr = 1'b0;
  bit   done = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference: access size and signedness from the opcode, then byte-level arithmetic.
  function automatic exp_t model(string name, logic [3:0] op, logic [31:0] addr,
                                 logic [31:0] wr, logic [31:0] rd);
    exp_t e;
    int unsigned size = 0, off;
    bit is_load = 0, is_store = 0, sgn = 0;
    logic [31:0] v;
    off = int'(addr % 4);
    case (op)
      4'd1:  begin is_load = 1; size = 1; sgn = 1; end
      4'd2:  begin is_load = 1; size = 2; sgn = 1; end
      4'd3:  begin is_load = 1; size = 4; end
      4'd4:  begin is_load = 1; size = 1; end
      4'd5:  begin is_load = 1; size = 2; end
      4'd8:  begin is_store = 1; size = 1; end
      4'd9:  begin is_store = 1; size = 2; end
      4'd10: begin is_store = 1; size = 4; end
      default: ;
    endcase
    e.name = name;
    e.addr = addr - off;
    e.wdata = 0; e.rdata = 0; e.mask = 0; e.en = 0; e.mis = 0; e.chk_w = 1;
    e.sticky = model_sticky;
    if (size != 0 && (off % size) != 0) begin
      e.mis = 1;
      e.chk_w = !is_store;
    end else if (is_load) begin
      e.en = 1;
      v = 0;
      for (int unsigned i = 0; i < size; i++)
        v = v | (((rd >> (8 * (off + i))) & 32'hFF) << (8 * i));
      if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      e.rdata = v;
    end else if (is_store) begin
      e.en = 1;
      e.mask = 4'(((1 << size) - 1) << off);
      for (int unsigned n = 0; n < 4; n++)
        e.wdata = e.wdata | (((wr >> (8 * (n % size))) & 32'hFF) << (8 * n));
    end
    return e;
  endfunction

  task automatic apply(string name, logic [3:0] op, logic [31:0] addr,
                       logic [31:0] wr, logic [31:0] rd, logic clr);
    exp_t e;
    @(posedge clk_i);
    #1;
    if (prev_clr) model_sticky = 1'b0;
    else if (prev_mis) model_sticky = 1'b1;
    lsu_opcode_i = op; addr_mem_i = addr; val_memwr_i = wr; val_memrd_i = rd;
    err_clr_i = clr;
    e = model(name, op, addr, wr, rd);
    prev_mis = e.mis;
    prev_clr = clr;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".addr"}, addr_mem_o, e.addr);
        check({e.name, ".rdata"}, val_memrd_o, e.rdata);
        check({e.name, ".mask"}, 32'(wr_mask_o), 32'(e.mask));
        check({e.name, ".en"}, 32'(enable_o), 32'(e.en));
        check({e.name, ".mis"}, 32'(misalign_o), 32'(e.mis));
        check({e.name, ".sticky"}, 32'(misalign_sticky_o), 32'(e.sticky));
        if (e.chk_w) check({e.name, ".wdata"}, val_memwr_o, e.wdata);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] D = 32'h0843_9341;

  initial begin : driver
    logic [3:0] op;
    #2;
    check("reset.sticky", 32'(misalign_sticky_o), 32'd0);
    #20;
    rst_ni = 1'b1;

    for (int unsigned o = 0; o < 4; o++) apply($sformatf("lbu_off%0d", o), 4'd4, o, 0, D, 0);
    apply("lb_off1", 4'd1, 1, 0, D, 0);
    apply("lb_off2", 4'd1, 2, 0, D, 0);
    apply("lhu_off0", 4'd5, 0, 0, D, 0);
    apply("lhu_off2", 4'd5, 2, 0, D, 0);
    apply("lh_off0", 4'd2, 0, 0, D, 0);
    apply("lw_off0", 4'd3, 0, 0, D, 0);
    apply("lh_addr1", 4'd2, 1, 0, D, 0);
    apply("clr0", 4'd0, 0, 0, 0, 1);
    for (int unsigned a = 4; a < 8; a++) apply($sformatf("sb_addr%0d", a), 4'd8, a, D, 0, 0);
    apply("sh_addr4", 4'd9, 4, D, 0, 0);
    apply("sh_addr6", 4'd9, 6, D, 0, 0);
    apply("sw_addr4", 4'd10, 4, D, 0, 0);
    apply("sw_addr7", 4'd10, 7, D, 0, 0);
    apply("none_hold1", 4'd0, 32'h1234_5677, 0, 0, 0);
    apply("none_hold2", 4'd0, 32'h0000_00FF, 0, 0, 0);
    apply("none_clr", 4'd0, 0, 0, 0, 1);
    apply("none_after_clr", 4'd0, 32'hDEAD_BEEF, 0, 0, 0);
    apply("clr_vs_mis", 4'd10, 3, D, 0, 1);
    apply("after_clr_vs_mis", 4'd0, 0, 0, 0, 0);
    apply("sw_addr7b", 4'd10, 7, D, 0, 0);
    apply("none_set", 4'd0, 32'h0000_0013, 0, 0, 0);

    @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check("async_reset.sticky", 32'(misalign_sticky_o), 32'd0);
    #1;
    rst_ni = 1'b1;
    model_sticky = 1'b0;
    prev_mis = 1'b0;
    prev_clr = 1'b0;
    apply("post_reset", 4'd0, 32'h0000_0042, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 10));
      apply($sformatf("rnd%0d", i), op, $urandom, $urandom, $urandom,
            ($urandom_range(0, 15) == 0));
    end

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("scoreboard.empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    done = 1'b1;
    $finish;
  end

endmodule
